// File: rtl/fft_out_serializer.sv
// Frame-to-stream back end of the 16-point FFT: captures a parallel frame, emits one word per beat.
// Define FFT_OUT_BITREV_EN to emit the bit-reversed frame in natural frequency order.
module fft_out_serializer #(
  parameter int N_PTS = 16,
  parameter int DW    = 32,
  parameter int IW    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic [N_PTS*DW-1:0] frame_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic [IW-1:0]       out_index,
  output logic                out_last
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_cnt;
  logic [DW-1:0] r_buf [N_PTS];

  logic          w_last_cnt;
  logic          w_beat;
  logic          w_frame_hs;
  logic [IW-1:0] w_slot;

`ifdef FFT_OUT_BITREV_EN
  function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] k);
    logic [IW-1:0] r;
    for (int i = 0; i < IW; i++) r[i] = k[IW-1-i];
    return r;
  endfunction

  assign w_slot = bitrev(r_cnt);
`else
  assign w_slot = r_cnt;
`endif

  assign w_last_cnt = (r_cnt == IW'(N_PTS - 1));
  assign out_valid  = (r_state == SEND);
  assign w_beat     = out_valid & out_ready;
  // The out_ready term lets a new frame land on the last beat with no bubble.
  assign frame_ready = (r_state == IDLE) | ((r_state == SEND) & w_last_cnt & out_ready);
  assign w_frame_hs  = frame_valid & frame_ready;

  assign out_data  = r_buf[w_slot];
  assign out_index = r_cnt;
  assign out_last  = w_last_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      // NOTE: the buffer is reset so out_data reads 0 the moment rst_n falls.
      for (int s = 0; s < N_PTS; s++) r_buf[s] <= '0;
    end else if (w_frame_hs) begin
      for (int s = 0; s < N_PTS; s++) r_buf[s] <= frame_data[s*DW +: DW];
      r_cnt   <= '0;
      r_state <= SEND;
    end else if (w_beat) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_last_cnt) r_state <= IDLE;
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer: queue-based reference model plus directed and random stimulus.
module tb_fft_out_serializer;

  localparam int N  = 16;
  localparam int DW = 32;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_valid = 1'b0;
  logic            frame_ready;
  logic [N*DW-1:0] frame_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [DW-1:0]   out_data;
  logic [3:0]      out_index;
  logic            out_last;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t       exp_q[$];
  logic [31:0] log_q[$];

  fft_out_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_index   (out_index),
    .out_last    (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int slot_of(input int k);
`ifdef FFT_OUT_BITREV_EN
    int r = 0;
    for (int i = 0; i < 4; i++) if (((k >> i) & 1) != 0) r += (1 << (3 - i));
    return r;
`else
    return k;
`endif
  endfunction

  function automatic logic [N*DW-1:0] std_frame();
    logic [N*DW-1:0] f;
    for (int s = 0; s < N; s++) begin
      logic [15:0] re, im;
      re = 16'(s);
      im = 16'(-s);
      f[s*DW +: DW] = {re, im};
    end
    return f;
  endfunction

  function automatic logic [N*DW-1:0] a_frame();
    logic [N*DW-1:0] f;
    for (int s = 0; s < N; s++) f[s*DW +: DW] = 32'hA000_0000 + 32'(s);
    return f;
  endfunction

  function automatic logic [N*DW-1:0] rnd_frame();
    logic [N*DW-1:0] f;
    for (int s = 0; s < N; s++) f[s*DW +: DW] = $urandom();
    return f;
  endfunction

  // Reference model: a frame is a queue of pending beats; the stream is the queue head.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q = {};
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data",  64'(out_data),  64'd0);
      check("rst_out_index", 64'(out_index), 64'd0);
    end else begin
      logic exp_valid, exp_ready;
      exp_valid = (exp_q.size() != 0);
      exp_ready = !exp_valid || (exp_q.size() == 1 && out_ready);
      check("frame_ready", 64'(frame_ready), 64'(exp_ready));
      check("out_valid",   64'(out_valid),   64'(exp_valid));
      if (exp_valid) begin
        check("out_data",  64'(out_data),  64'(exp_q[0].data));
        check("out_index", 64'(out_index), 64'(exp_q[0].idx));
        check("out_last",  64'(out_last),  64'(exp_q[0].idx == 4'd15));
        if (out_ready) begin
          log_q.push_back(out_data);
          void'(exp_q.pop_front());
        end
      end
      if (frame_valid && exp_ready) begin
        for (int k = 0; k < N; k++) begin
          beat_t b;
          b.data = frame_data[slot_of(k)*DW +: DW];
          b.idx  = 4'(k);
          exp_q.push_back(b);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [N*DW-1:0] d);
    logic ok;
    ok = 1'b0;
    frame_data  = d;
    frame_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    frame_valid = 1'b0;
    check("frame_accept", 64'(ok), 64'd1);
  endtask

  initial begin
    int base;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [3:0] pat;
    pat = 4'b1001;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Reset mid-frame at beat 5
    send_frame(std_frame());
    step(5);
    #1;
    check("pre_rst_index", 64'(out_index), 64'd5);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data",  64'(out_data),  64'd0);
    step(2);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(frame_ready), 64'd1);
    base = log_q.size();
    step(10);
    check("post_rst_no_beats", 64'(log_q.size() - base), 64'd0);

    // Plain frame with out_ready held high
    base = log_q.size();
    send_frame(std_frame());
    step(20);
    check("f_beats", 64'(log_q.size() - base), 64'd16);
    check("f_beat0",  64'(log_q[base]),      64'h0000_0000);
`ifdef FFT_OUT_BITREV_EN
    check("f_beat1",  64'(log_q[base + 1]),  64'h0008_FFF8);
    check("f_beat2",  64'(log_q[base + 2]),  64'h0004_FFFC);
`else
    check("f_beat1",  64'(log_q[base + 1]),  64'h0001_FFFF);
    check("f_beat2",  64'(log_q[base + 2]),  64'h0002_FFFE);
`endif
    check("f_beat15", 64'(log_q[base + 15]), 64'h000F_FFF1);

    // Backpressure 1,0,0,1 repeating
    base = log_q.size();
    send_frame(std_frame());
    for (int i = 0; i < 64; i++) begin
      out_ready = pat[i % 4];
      step(1);
    end
    out_ready = 1'b1;
    step(4);
    check("bp_beats",  64'(log_q.size() - base), 64'd16);
    check("bp_beat15", 64'(log_q[base + 15]),    64'h000F_FFF1);

    // Back-to-back frames with frame_valid held
    base = log_q.size();
    send_frame(std_frame());
    send_frame(a_frame());
    step(20);
    check("b2b_beats",  64'(log_q.size() - base), 64'd32);
    check("b2b_f2_b0",  64'(log_q[base + 16]),    64'hA000_0000);
`ifdef FFT_OUT_BITREV_EN
    check("b2b_f2_b1",  64'(log_q[base + 17]),    64'hA000_0008);
`else
    check("b2b_f2_b1",  64'(log_q[base + 17]),    64'hA000_0001);
`endif

    // frame_valid pulsed during beats 0-14 must be ignored
    base = log_q.size();
    send_frame(std_frame());
    for (int i = 0; i < 15; i++) begin
      frame_valid = (i % 2 == 0);
      frame_data  = rnd_frame();
      step(1);
    end
    frame_valid = 1'b0;
    step(20);
    check("ign_beats",  64'(log_q.size() - base), 64'd16);
    check("ign_beat15", 64'(log_q[base + 15]),    64'h000F_FFF1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      out_ready   = ($urandom_range(0, 9) < 7);
      frame_valid = ($urandom_range(0, 9) < 3);
      frame_data  = rnd_frame();
      step(1);
    end
    frame_valid = 1'b0;
    out_ready   = 1'b1;
    step(40);
    check("drain_idle", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
